// File: rtl/axil_pkg.sv
// axil_pkg: shared encodings for the AXI-lite load path.
// Rev 1.0
`default_nettype none

package axil_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic RRESP_OKAY = 1'b0;
  localparam logic RRESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // Size 3 is treated as a word, so anything above half needs full alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_axil_read_master_if.sv
// lsu_axil_read_master_if: single-beat AXI-lite AR/R channel bundle.
// Rev 1.0
`default_nettype none

interface lsu_axil_read_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

`default_nettype wire

// File: rtl/load_align_extend.sv
// load_align_extend: picks the addressed byte/half out of a 32-bit word and extends it.
// Rev 1.0
`default_nettype none

module load_align_extend
  import axil_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: data = {{(DATA_W-8){~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: data = {{(DATA_W-16){~is_unsigned & lane[15]}}, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_axil_read_master.sv
// lsu_axil_read_master: one-outstanding load request -> AXI-lite AR/R -> registered response.
// Rev 1.0
`default_nettype none

module lsu_axil_read_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              resp_misalign,
  lsu_axil_read_master_if.master bus
);

  state_t            state_q, state_n;
  logic [1:0]        off_q, off_n;
  logic [1:0]        size_q, size_n;
  logic              uns_q, uns_n;
  logic [ADDR_W-1:0] araddr_q, araddr_n;
  logic              arvalid_q, arvalid_n;
  logic              rready_q, rready_n;
  logic              req_ready_n;
  logic              resp_valid_n;
  logic [DATA_W-1:0] resp_data_n;
  logic              resp_err_n;
  logic              resp_misalign_n;
  logic [DATA_W-1:0] aligned;

  load_align_extend #(.DATA_W(DATA_W)) u_align (
    .rdata       (bus.rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (aligned)
  );

  always_comb begin
    state_n         = state_q;
    off_n           = off_q;
    size_n          = size_q;
    uns_n           = uns_q;
    araddr_n        = araddr_q;
    arvalid_n       = arvalid_q;
    rready_n        = rready_q;
    req_ready_n     = req_ready;
    resp_valid_n    = resp_valid;
    resp_data_n     = resp_data;
    resp_err_n      = resp_err;
    resp_misalign_n = resp_misalign;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          off_n       = req_addr[1:0];
          size_n      = req_size;
          uns_n       = req_unsigned;
          req_ready_n = 1'b0;
          // Misaligned loads never touch the bus; they complete locally as errors.
          if (is_misaligned(req_size, req_addr[1:0])) begin
            resp_valid_n    = 1'b1;
            resp_err_n      = 1'b1;
            resp_misalign_n = 1'b1;
            resp_data_n     = '0;
            state_n         = RESP;
          end else begin
            araddr_n  = {req_addr[ADDR_W-1:2], 2'b00};
            arvalid_n = 1'b1;
            state_n   = ADDR;
          end
        end
      end
      ADDR: begin
        if (bus.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bus.rvalid && rready_q) begin
          rready_n        = 1'b0;
          resp_valid_n    = 1'b1;
          resp_data_n     = aligned;
          resp_err_n      = (bus.rresp == RRESP_ERR);
          resp_misalign_n = 1'b0;
          state_n         = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_n = 1'b0;
          req_ready_n  = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= 2'b00;
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
    end else begin
      state_q       <= state_n;
      off_q         <= off_n;
      size_q        <= size_n;
      uns_q         <= uns_n;
      araddr_q      <= araddr_n;
      arvalid_q     <= arvalid_n;
      rready_q      <= rready_n;
      req_ready     <= req_ready_n;
      resp_valid    <= resp_valid_n;
      resp_data     <= resp_data_n;
      resp_err      <= resp_err_n;
      resp_misalign <= resp_misalign_n;
    end
  end

  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_axil_read_master.sv
// tb_lsu_axil_read_master: directed and randomized loads against an arithmetic load model.
// Rev 1.0
`default_nettype none

module tb_lsu_axil_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_misalign;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  bit mon_en = 1'b0;
  bit ar_hold = 1'b0;

  lsu_axil_read_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_axil_read_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .resp_misalign (resp_misalign),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] size, input bit uns);
    longint unsigned v;
    int sh;
    sh = 8 * int'(addr % 4);
    if (size == 2'd0) begin
      v = (longint'(rd) >> sh) % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (longint'(rd) >> sh) % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  // Protocol invariants sampled mid-cycle.
  always @(posedge clk) ar_hold <= bus.arvalid && !bus.arready;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("inv_ar_r_excl", 32'(bus.arvalid && bus.rready), 32'd0);
      check("inv_onehot0", 32'($onehot0({bus.arvalid, bus.rready, resp_valid})), 32'd1);
      check("inv_req_ready_idle", 32'(req_ready && (bus.arvalid || bus.rready || resp_valid)), 32'd0);
      if (ar_hold) check("inv_arvalid_held", 32'(bus.arvalid), 32'd1);
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input bit uns,
                         input logic [31:0] rd, input bit rr, input int ar_wait, input int resp_wait);
    logic [31:0] exp_data;
    bit          mis;
    mis      = ref_misaligned(addr, size);
    exp_data = mis ? 32'd0 : ref_load(rd, addr, size, uns);

    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    check("acc_req_ready", 32'(req_ready), 32'd0);

    if (!mis) begin
      check("ar_valid", 32'(bus.arvalid), 32'd1);
      check("ar_addr", bus.araddr, addr & 32'hFFFF_FFFC);
      for (int i = 0; i < ar_wait; i++) begin
        @(negedge clk);
        check("ar_hold_valid", 32'(bus.arvalid), 32'd1);
        check("ar_hold_addr", bus.araddr, addr & 32'hFFFF_FFFC);
        check("ar_hold_req_ready", 32'(req_ready), 32'd0);
      end
      bus.arready = 1'b1;
      @(negedge clk);
      bus.arready = 1'b0;
      check("ar_done_valid", 32'(bus.arvalid), 32'd0);
      check("r_ready", 32'(bus.rready), 32'd1);
      bus.rvalid = 1'b1;
      bus.rdata  = rd;
      bus.rresp  = rr;
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 1'b0;
      check("r_done_ready", 32'(bus.rready), 32'd0);
    end

    for (int i = 0; i <= resp_wait; i++) begin
      if (i > 0) @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_data", resp_data, exp_data);
      check("resp_err", 32'(resp_err), 32'(mis || rr));
      check("resp_misalign", 32'(resp_misalign), 32'(mis));
      check("resp_arvalid", 32'(bus.arvalid), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done_valid", 32'(resp_valid), 32'd0);
    check("resp_done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    resp_ready   = 1'b0;
    bus.arready  = 1'b0;
    bus.rvalid   = 1'b0;
    bus.rdata    = '0;
    bus.rresp    = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_rready", 32'(bus.rready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_misalign", 32'(resp_misalign), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    do_load(32'h0200_BFF8, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 0, 0);
    do_load(32'h0000_1003, 2'd0, 1'b0, 32'h80FF_0011, 1'b0, 1, 0);
    do_load(32'h0000_1003, 2'd0, 1'b1, 32'h80FF_0011, 1'b0, 0, 0);
    do_load(32'h0000_1001, 2'd0, 1'b0, 32'h80FF_0011, 1'b0, 0, 0);
    do_load(32'h0000_2002, 2'd1, 1'b0, 32'h8001_7FFF, 1'b0, 0, 1);
    do_load(32'h0000_2000, 2'd1, 1'b0, 32'h8001_7FFF, 1'b0, 0, 0);
    do_load(32'h0000_1002, 2'd2, 1'b0, 32'hAAAA_5555, 1'b0, 0, 0);
    do_load(32'h0000_1001, 2'd1, 1'b0, 32'hAAAA_5555, 1'b0, 0, 0);
    do_load(32'h0000_3004, 2'd3, 1'b1, 32'hCAFE_F00D, 1'b0, 5, 3);
    do_load(32'h0000_4008, 2'd2, 1'b0, 32'h0BAD_0BAD, 1'b1, 0, 3);

    for (int n = 0; n < 40; n++) begin
      do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 4) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Abandon a load while waiting on R.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_5000;
    req_size  = 2'd2;
    @(negedge clk);
    req_valid   = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("pre_rst_rready", 32'(bus.rready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rready", 32'(bus.rready), 32'd0);
    check("async_rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd1);
    #1 rst = 1'b0;
    do_load(32'h0000_6000, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
